// File: rtl/wb_divisor_register_slave.sv
// Wishbone pipelined slave for the 32-bit clock divisor: HIGH/LOW halves, atomic LOW commit, read snapshot.
// ACK_O returns ACK_LATENCY cycles after accept; the bus is stalled only while the DSP loads.
module wb_divisor_register_slave #(
  parameter int                           WISHBONE_DATAWIDTH    = 15,
  parameter int                           WISHBONE_ADDRESSWIDTH = 15,
  parameter logic [WISHBONE_ADDRESSWIDTH:0] DATA_HIGH           = 16'h400A,
  parameter logic [WISHBONE_ADDRESSWIDTH:0] DATA_LOW            = 16'h400B,
  parameter int                           ACK_LATENCY           = 2,
  parameter logic [31:0]                  RESET_DIVISOR         = 32'h0000_0000
) (
  input  logic                             CLK_I,
  input  logic                             RST_I,
  input  logic                             CYC_I,
  input  logic                             STB_I,
  input  logic                             WE_I,
  input  logic [WISHBONE_ADDRESSWIDTH:0]   ADR_I,
  input  logic [WISHBONE_DATAWIDTH:0]      DAT_I,
  output logic [WISHBONE_DATAWIDTH:0]      DAT_O,
  output logic                             ACK_O,
  output logic                             STALL_O,
  input  logic                             dsp_load,
  input  logic [31:0]                      dsp_divisor,
  output logic [31:0]                      divisor_out,
  output logic                             divisor_update
);

  localparam int DW = WISHBONE_DATAWIDTH + 1;

  logic [31:0]            divisor_q, divisor_d;
  logic [15:0]            hi_stage_q, hi_stage_d;
  logic [15:0]            lo_snap_q, lo_snap_d;
  logic                   snap_valid_q, snap_valid_d;
  logic                   update_q, update_d;
  logic [ACK_LATENCY-1:0] vld_q, vld_d;
  logic [DW-1:0]          dat_q [ACK_LATENCY];
  logic [DW-1:0]          dat_d [ACK_LATENCY];
  logic                   accept;
  logic                   hit_hi, hit_lo;
  logic [DW-1:0]          rdata;

  assign STALL_O        = dsp_load;
  assign ACK_O          = vld_q[ACK_LATENCY-1] & CYC_I;
  assign DAT_O          = ACK_O ? dat_q[ACK_LATENCY-1] : '0;
  assign divisor_out    = divisor_q;
  assign divisor_update = update_q;

  always_comb begin
    accept       = CYC_I & STB_I & ~dsp_load;
    hit_hi       = (ADR_I == DATA_HIGH);
    hit_lo       = (ADR_I == DATA_LOW);
    divisor_d    = divisor_q;
    hi_stage_d   = hi_stage_q;
    lo_snap_d    = lo_snap_q;
    snap_valid_d = snap_valid_q;
    update_d     = 1'b0;
    rdata        = '0;
    if (dsp_load) begin
      divisor_d = dsp_divisor;
      update_d  = 1'b1;
    end else if (accept) begin
      if (WE_I) begin
        if (hit_hi) begin
          hi_stage_d = DAT_I;
        end else if (hit_lo) begin
          divisor_d = {hi_stage_q, DAT_I};
          update_d  = 1'b1;
        end
      end else begin
        // HIGH read freezes the low half so the following LOW read is coherent
        if (hit_hi) begin
          rdata        = divisor_q[31:16];
          lo_snap_d    = divisor_q[15:0];
          snap_valid_d = 1'b1;
        end else if (hit_lo) begin
          rdata        = snap_valid_q ? lo_snap_q : divisor_q[15:0];
          snap_valid_d = 1'b0;
        end
      end
    end
    if (!CYC_I) snap_valid_d = 1'b0;
  end

  always_comb begin
    vld_d[0] = accept;
    dat_d[0] = rdata;
    for (int i = 1; i < ACK_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1] & CYC_I;
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      divisor_q    <= RESET_DIVISOR;
      hi_stage_q   <= '0;
      lo_snap_q    <= '0;
      snap_valid_q <= 1'b0;
      update_q     <= 1'b0;
      vld_q        <= '0;
      for (int i = 0; i < ACK_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      divisor_q    <= divisor_d;
      hi_stage_q   <= hi_stage_d;
      lo_snap_q    <= lo_snap_d;
      snap_valid_q <= snap_valid_d;
      update_q     <= update_d;
      vld_q        <= vld_d;
      for (int i = 0; i < ACK_LATENCY; i++) dat_q[i] <= dat_d[i];
    end
  end

endmodule

// File: doc/wb_divisor_register_slave.md
Name: wb_divisor_register_slave

Overview:
- Wishbone pipelined-mode slave that owns the 32-bit clock-divisor register.
- Bus masters, such as the clock divisor's read engine, read this register as two 16-bit halves at DATA_HIGH/DATA_LOW. Other masters may also write it.
- The DSP side loads new divisor values directly. Every change produces a divisor_update pulse that tells masters to re-fetch.
- Sits on the shared Wishbone interconnect, which handles arbitration and GNT; this block only sees the slave side.

Parameters:
WISHBONE_DATAWIDTH, 15, MSB index of data bus (bus is 16 bits)
WISHBONE_ADDRESSWIDTH, 15, MSB index of address bus (bus is 16 bits)
DATA_HIGH, 16'h400A, address of divisor[31:16]
DATA_LOW, 16'h400B, address of divisor[15:0]
ACK_LATENCY, 2, cycles from request acceptance to ACK_O; legal range 1..4
RESET_DIVISOR, 32'h0000_0000, divisor value after reset

Ports:
CLK_I  in  1  system clock; all logic on rising edge
RST_I  in  1  synchronous, active-high reset
CYC_I  in  1  bus cycle active
STB_I  in  1  request strobe
WE_I  in  1  1 = write, 0 = read
ADR_I  in  16  word address
DAT_I  in  16  write data
DAT_O  out  16  read data, valid when ACK_O = 1
ACK_O  out  1  one pulse per accepted request, in order
STALL_O  out  1  request not accepted this cycle
dsp_load  in  1  load dsp_divisor into the divisor register
dsp_divisor  in  32  divisor value from DSP
divisor_out  out  32  current committed divisor
divisor_update  out  1  one-cycle pulse after any divisor change

Behaviour:
- Accept condition: CYC_I & STB_I & ~STALL_O. At most one request is accepted per cycle.
- STALL_O = dsp_load (combinational). The bus and the DSP therefore never commit in the same cycle.
- Decode and data effects happen at accept time. Pending responses do not re-read state.
- Write to DATA_HIGH: hi_stage <= DAT_I. divisor_reg is unchanged.
- Write to DATA_LOW: divisor_reg <= {hi_stage, DAT_I}. This is an atomic 32-bit commit.
- Read of DATA_HIGH:
  - returns divisor_reg[31:16];
  - latches lo_snap <= divisor_reg[15:0] and sets snap_valid.
- Read of DATA_LOW:
  - returns lo_snap if snap_valid, else divisor_reg[15:0];
  - clears snap_valid.
- The snapshot mechanism guarantees a coherent 32-bit HIGH-then-LOW read pair even if dsp_load fires between the two reads.
- Unmapped address:
  - write is ignored;
  - read returns 16'h0000;
  - ACK is still issued (no ERR_O).
- dsp_load = 1: divisor_reg <= dsp_divisor. hi_stage is unchanged.
- divisor_update:
  - registered; high for exactly one cycle, the cycle after any commit (bus LOW write or dsp_load);
  - that is the same cycle divisor_out first shows the new value;
  - pulses even if the new value equals the old one.
- Response pipeline: shift register ACK_LATENCY deep of {valid, rdata}.
  - A request accepted at cycle N gives ACK_O = 1 with DAT_O at cycle N+ACK_LATENCY.
  - Back-to-back accepts give back-to-back ACKs, so no internal stall is needed.
- DAT_O is 16'h0000 when ACK_O = 0. Write ACKs also drive 16'h0000.
- CYC_I low:
  - flushes all pipeline valid bits the same cycle;
  - forces ACK_O = 0;
  - clears snap_valid.
- Writes already accepted before CYC_I drops remain committed.
- Reset (RST_I = 1 at clock edge):
  - divisor_reg = RESET_DIVISOR, hi_stage = 0, snap_valid = 0, pipeline cleared;
  - ACK_O = 0, DAT_O = 0, divisor_update = 0;
  - STALL_O still follows dsp_load, but dsp_load is ignored during reset.
- Reset mid-transaction drops all pending ACKs. No divisor_update pulse is generated by reset.
- dsp_load held high for several cycles: reloads every cycle, pulses every cycle, and stalls the bus throughout.

Test Plan:
- Reset, then read DATA_HIGH and DATA_LOW pipelined (ACK_LATENCY = 2), accepted at cycles 0 and 1 -> ACK at cycles 2 and 3 with DAT_O 16'h0000, 16'h0000.
- Write 16'h0001 to 400A, then 16'h86A0 to 400B -> divisor_out = 32'h0001_86A0 one cycle after the LOW accept; divisor_update high for exactly that cycle; two ACKs.
- Read 400A (returns 16'h0001); then dsp_load with 32'h1234_5678; then read 400B -> STALL_O high during the dsp_load cycle; second read returns 16'h86A0 (snapshot); a following fresh read of 400B returns 16'h5678.
- Read 16'h4000 and write 16'h4001 (unmapped) -> both ACKed, read data 16'h0000, divisor_out unchanged, no divisor_update.
- Three reads back-to-back, then CYC_I dropped one cycle after the last accept -> at most one ACK observed before the drop; no ACK_O while CYC_I = 0.
- Write HIGH accepted, then RST_I asserted before the ACK -> no ACK, hi_stage = 0, divisor_out = RESET_DIVISOR, divisor_update stays 0.
